// File: rtl/dec_ctrl_if.sv
// ============================================================================
// Module : dec_ctrl_if
// Decode-controller bus: opcode/flags/interrupt inputs and control outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dec_ctrl_if #(
  parameter int N_IRQ = 4
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [4:0]       op_code_i;
  logic [3:0]       flags_alu_i;
  logic [N_IRQ-1:0] irq_i;
  logic [N_IRQ-1:0] irq_mask_i;
  logic [1:0]       mode_pc_o;
  logic             stall_o;
  logic             wr_en_rf_o;
  logic             a_imm_alu_o;
  logic [2:0]       func_alu_o;
  logic             irq_taken_o;
  logic [ID_W-1:0]  irq_id_o;
  logic             halted_o;
  logic             sleeping_o;
  logic             illegal_o;

  modport slave (
    input  op_code_i, flags_alu_i, irq_i, irq_mask_i,
    output mode_pc_o, stall_o, wr_en_rf_o, a_imm_alu_o, func_alu_o,
           irq_taken_o, irq_id_o, halted_o, sleeping_o, illegal_o
  );

  modport master (
    output op_code_i, flags_alu_i, irq_i, irq_mask_i,
    input  mode_pc_o, stall_o, wr_en_rf_o, a_imm_alu_o, func_alu_o,
           irq_taken_o, irq_id_o, halted_o, sleeping_o, illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/dec_ctrl.sv
// ============================================================================
// Module : dec_ctrl
// Instruction decode / sequencing controller with multi-cycle MUL, WFI sleep,
// vectored interrupt entry and sticky illegal-opcode halt.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dec_ctrl #(
  parameter int N_IRQ      = 4,
  parameter int MUL_CYCLES = 3
) (
  input  wire        clk_i,
  input  wire        rst_ni,
  dec_ctrl_if.slave  bus
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // Opcode map: bit4 = immediate operand, bit3 = control op, bits[2:0] = ALU function
  localparam logic [4:0] c_OP_BEQ  = 5'h08;
  localparam logic [4:0] c_OP_BNE  = 5'h09;
  localparam logic [4:0] c_OP_JSBR = 5'h0A;
  localparam logic [4:0] c_OP_RSBR = 5'h0B;
  localparam logic [4:0] c_OP_WFI  = 5'h0C;
  localparam logic [4:0] c_OP_HALT = 5'h0D;

  localparam logic [2:0] c_F_SUB = 3'd1;
  localparam logic [2:0] c_F_MUL = 3'd5;

  localparam logic [1:0] c_PC_INCREMENT  = 2'd0;
  localparam logic [1:0] c_PC_RELATIVE   = 2'd1;
  localparam logic [1:0] c_PC_SUBROUTINE = 2'd2;
  localparam logic [1:0] c_PC_RETURN     = 2'd3;

  localparam logic [3:0] c_CNT_LAST = 4'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_MULW  = 3'd1,
    S_SLEEP = 3'd2,
    S_WAKE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           r_state, w_state_d;
  logic [N_IRQ-1:0] r_pend, w_pend_d;
  logic             r_in_isr, w_in_isr_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic             r_illegal, w_illegal_d;

  logic [N_IRQ-1:0] w_ready;
  logic [N_IRQ-1:0] w_take_vec;
  logic [N_IRQ-1:0] w_low_vec;
  logic [ID_W-1:0]  w_low_id;
  logic [ID_W-1:0]  w_irq_id;
  logic [1:0]       w_mode_pc;
  logic             w_stall;
  logic             w_wr_en;
  logic             w_taken;

  assign w_ready = r_pend & bus.irq_mask_i;

  // Lowest-index ready channel wins
  always_comb begin
    w_low_id  = '0;
    w_low_vec = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_low_id  = ID_W'(i);
        w_low_vec = '0;
        w_low_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_mode_pc   = c_PC_INCREMENT;
    w_stall     = 1'b0;
    w_wr_en     = 1'b0;
    w_taken     = 1'b0;
    w_irq_id    = '0;
    w_take_vec  = '0;
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_in_isr_d  = r_in_isr;
    w_illegal_d = r_illegal;

    // Outputs held at their idle values while reset is applied
    if (rst_ni) begin
      unique case (r_state)
        S_RUN: begin
          if (!r_in_isr && (w_ready != '0)) begin
            w_taken    = 1'b1;
            w_mode_pc  = c_PC_SUBROUTINE;
            w_irq_id   = w_low_id;
            w_take_vec = w_low_vec;
            w_in_isr_d = 1'b1;
          end else if (!bus.op_code_i[3]) begin
            if ((bus.op_code_i[2:0] == c_F_MUL) && (MUL_CYCLES > 1)) begin
              w_stall   = 1'b1;
              w_state_d = S_MULW;
              w_cnt_d   = 4'd1;
            end else begin
              w_wr_en = 1'b1;
            end
          end else begin
            unique case (bus.op_code_i)
              c_OP_BEQ:  if (bus.flags_alu_i[0])  w_mode_pc = c_PC_RELATIVE;
              c_OP_BNE:  if (!bus.flags_alu_i[0]) w_mode_pc = c_PC_RELATIVE;
              c_OP_JSBR: w_mode_pc = c_PC_SUBROUTINE;
              c_OP_RSBR: begin
                w_mode_pc  = c_PC_RETURN;
                w_in_isr_d = 1'b0;
              end
              c_OP_WFI: begin
                if ((w_ready == '0) && !r_in_isr) begin
                  w_stall   = 1'b1;
                  w_state_d = S_SLEEP;
                end
              end
              c_OP_HALT: begin
                w_stall   = 1'b1;
                w_state_d = S_HALT;
              end
              default: begin
                w_stall     = 1'b1;
                w_state_d   = S_HALT;
                w_illegal_d = 1'b1;
              end
            endcase
          end
        end
        S_MULW: begin
          if (r_cnt < c_CNT_LAST) begin
            w_stall = 1'b1;
            w_cnt_d = r_cnt + 4'd1;
          end else begin
            w_wr_en   = 1'b1;
            w_cnt_d   = 4'd0;
            w_state_d = S_RUN;
          end
        end
        S_SLEEP: begin
          w_stall = 1'b1;
          if (w_ready != '0) w_state_d = S_WAKE;
        end
        S_WAKE: begin
          w_state_d = S_RUN;
        end
        S_HALT: begin
          w_stall = 1'b1;
        end
        default: begin
          w_state_d = S_RUN;
        end
      endcase
    end

    w_pend_d = (r_pend | bus.irq_i) & ~w_take_vec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_RUN;
      r_pend    <= '0;
      r_in_isr  <= 1'b0;
      r_cnt     <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pend    <= w_pend_d;
      r_in_isr  <= w_in_isr_d;
      r_cnt     <= w_cnt_d;
      r_illegal <= w_illegal_d;
    end
  end

  assign bus.mode_pc_o   = w_mode_pc;
  assign bus.stall_o     = w_stall;
  assign bus.wr_en_rf_o  = w_wr_en;
  assign bus.irq_taken_o = w_taken;
  assign bus.irq_id_o    = w_irq_id;
  assign bus.a_imm_alu_o = bus.op_code_i[4];
  assign bus.func_alu_o  = bus.op_code_i[3] ? c_F_SUB : bus.op_code_i[2:0];
  assign bus.halted_o    = (r_state == S_HALT);
  assign bus.sleeping_o  = (r_state == S_SLEEP);
  assign bus.illegal_o   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_dec_ctrl.sv
// ============================================================================
// Module : tb_dec_ctrl
// Directed self-checking bench for dec_ctrl (N_IRQ=4, MUL_CYCLES=3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dec_ctrl;
  localparam logic [4:0] ADD  = 5'h00;
  localparam logic [4:0] ADDI = 5'h10;
  localparam logic [4:0] MUL  = 5'h05;
  localparam logic [4:0] NOTI = 5'h17;
  localparam logic [4:0] BEQ  = 5'h08;
  localparam logic [4:0] BNE  = 5'h09;
  localparam logic [4:0] JSBR = 5'h0A;
  localparam logic [4:0] RSBR = 5'h0B;
  localparam logic [4:0] WFI  = 5'h0C;
  localparam logic [4:0] HLT  = 5'h0D;
  localparam logic [4:0] ILL  = 5'h1F;

  localparam logic [1:0] INC = 2'd0;
  localparam logic [1:0] REL = 2'd1;
  localparam logic [1:0] SUB = 2'd2;
  localparam logic [1:0] RET = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dec_ctrl_if #(.N_IRQ(4)) bus ();

  dec_ctrl #(.N_IRQ(4), .MUL_CYCLES(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // {mode_pc, stall, wr_en, irq_taken, irq_id, halted, sleeping, illegal}
  function automatic logic [9:0] outs();
    return {bus.mode_pc_o, bus.stall_o, bus.wr_en_rf_o, bus.irq_taken_o,
            bus.irq_id_o, bus.halted_o, bus.sleeping_o, bus.illegal_o};
  endfunction

  function automatic logic [9:0] pk(input logic [1:0] m, input logic s, input logic w,
                                    input logic t, input logic [1:0] id, input logic h,
                                    input logic sl, input logic il);
    return {m, s, w, t, id, h, sl, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.op_code_i   = NOTI;
    bus.flags_alu_i = 4'h0;
    bus.irq_i       = 4'h0;
    bus.irq_mask_i  = 4'h0;
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== pk(INC, 0, 0, 0, 2'd0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b exp %b", outs(), pk(INC, 0, 0, 0, 2'd0, 0, 0, 0));
    end
    n_checks++;
    if ({bus.a_imm_alu_o, bus.func_alu_o} !== 4'b1_111) begin
      n_errors++;
      $display("FAIL decode_noti: got %b exp %b", {bus.a_imm_alu_o, bus.func_alu_o}, 4'b1_111);
    end
    bus.op_code_i = BEQ;
    #1;
    n_checks++;
    if ({bus.a_imm_alu_o, bus.func_alu_o} !== 4'b0_001) begin
      n_errors++;
      $display("FAIL decode_beq_sub: got %b exp %b", {bus.a_imm_alu_o, bus.func_alu_o}, 4'b0_001);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [4:0] ops [2] = '{ADD, ADDI};
    for (int i = 0; i < 2; i++) begin
      bus.op_code_i = ops[i];
      @(negedge clk);
      n_checks++;
      if (outs() !== pk(INC, 0, 1, 0, 2'd0, 0, 0, 0)) begin
        n_errors++;
        $display("FAIL alu_%0d: got %b exp %b", i, outs(), pk(INC, 0, 1, 0, 2'd0, 0, 0, 0));
      end
      tick();
    end
  endtask

  task automatic test_mul();
    logic [4:0] ops [5] = '{MUL, MUL, MUL, ADD, RSBR};
    logic [3:0] irq [5] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [9:0] exp [5];
    exp[0] = pk(INC, 1, 0, 0, 2'd0, 0, 0, 0);
    exp[1] = pk(INC, 1, 0, 0, 2'd0, 0, 0, 0);
    exp[2] = pk(INC, 0, 1, 0, 2'd0, 0, 0, 0);
    exp[3] = pk(SUB, 0, 0, 1, 2'd0, 0, 0, 0);
    exp[4] = pk(RET, 0, 0, 0, 2'd0, 0, 0, 0);
    bus.irq_mask_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      bus.op_code_i = ops[i];
      bus.irq_i     = irq[i];
      @(negedge clk);
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++;
        $display("FAIL mul_cycle%0d: got %b exp %b", i, outs(), exp[i]);
      end
      tick();
    end
    bus.irq_mask_i = 4'h0;
  endtask

  task automatic test_irq_priority();
    logic [4:0] ops [6] = '{ADD, ADD, ADD, RSBR, ADD, RSBR};
    logic [3:0] irq [6] = '{4'b1010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [9:0] exp [6];
    exp[0] = pk(INC, 0, 1, 0, 2'd0, 0, 0, 0);
    exp[1] = pk(SUB, 0, 0, 1, 2'd1, 0, 0, 0);
    exp[2] = pk(INC, 0, 1, 0, 2'd0, 0, 0, 0);
    exp[3] = pk(RET, 0, 0, 0, 2'd0, 0, 0, 0);
    exp[4] = pk(SUB, 0, 0, 1, 2'd3, 0, 0, 0);
    exp[5] = pk(RET, 0, 0, 0, 2'd0, 0, 0, 0);
    bus.irq_mask_i = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      bus.op_code_i = ops[i];
      bus.irq_i     = irq[i];
      @(negedge clk);
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++;
        $display("FAIL irq_cycle%0d: got %b exp %b", i, outs(), exp[i]);
      end
      tick();
    end
    bus.irq_mask_i = 4'h0;
  endtask

  task automatic test_branch();
    logic [4:0] ops  [5] = '{BEQ, BNE, BEQ, BNE, JSBR};
    logic [3:0] flg  [5] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [1:0] mode [5] = '{REL, INC, INC, REL, SUB};
    for (int i = 0; i < 5; i++) begin
      bus.op_code_i   = ops[i];
      bus.flags_alu_i = flg[i];
      @(negedge clk);
      n_checks++;
      if (outs() !== pk(mode[i], 0, 0, 0, 2'd0, 0, 0, 0)) begin
        n_errors++;
        $display("FAIL branch_%0d: got %b exp %b", i, outs(), pk(mode[i], 0, 0, 0, 2'd0, 0, 0, 0));
      end
      tick();
    end
    bus.flags_alu_i = 4'h0;
  endtask

  task automatic test_wfi();
    logic [4:0] ops [6] = '{WFI, WFI, WFI, WFI, ADD, RSBR};
    logic [3:0] irq [6] = '{4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [9:0] exp [6];
    exp[0] = pk(INC, 1, 0, 0, 2'd0, 0, 0, 0);
    exp[1] = pk(INC, 1, 0, 0, 2'd0, 0, 1, 0);
    exp[2] = pk(INC, 1, 0, 0, 2'd0, 0, 1, 0);
    exp[3] = pk(INC, 0, 0, 0, 2'd0, 0, 0, 0);
    exp[4] = pk(SUB, 0, 0, 1, 2'd2, 0, 0, 0);
    exp[5] = pk(RET, 0, 0, 0, 2'd0, 0, 0, 0);
    bus.irq_mask_i = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      bus.op_code_i = ops[i];
      bus.irq_i     = irq[i];
      @(negedge clk);
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++;
        $display("FAIL wfi_cycle%0d: got %b exp %b", i, outs(), exp[i]);
      end
      tick();
    end
    bus.irq_mask_i = 4'h0;
  endtask

  task automatic test_halt_reset();
    logic [4:0] ops [11] = '{ILL, ADD, ADD, ADD, ADD, HLT, ADD, MUL, MUL, MUL, ADD};
    logic [3:0] irq [11] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       rst [11] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1};
    logic [9:0] exp [11];
    exp[0]  = pk(INC, 1, 0, 0, 2'd0, 0, 0, 0);
    exp[1]  = pk(INC, 1, 0, 0, 2'd0, 1, 0, 1);
    exp[2]  = pk(INC, 1, 0, 0, 2'd0, 1, 0, 1);
    exp[3]  = pk(INC, 0, 0, 0, 2'd0, 0, 0, 0);
    exp[4]  = pk(INC, 0, 1, 0, 2'd0, 0, 0, 0);
    exp[5]  = pk(INC, 1, 0, 0, 2'd0, 0, 0, 0);
    exp[6]  = pk(INC, 1, 0, 0, 2'd0, 1, 0, 0);
    exp[7]  = pk(INC, 0, 0, 0, 2'd0, 0, 0, 0);
    exp[8]  = pk(INC, 1, 0, 0, 2'd0, 0, 0, 0);
    exp[9]  = pk(INC, 0, 0, 0, 2'd0, 0, 0, 0);
    exp[10] = pk(INC, 0, 1, 0, 2'd0, 0, 0, 0);
    bus.irq_mask_i = 4'b0001;
    for (int i = 0; i < 11; i++) begin
      bus.op_code_i = ops[i];
      bus.irq_i     = irq[i];
      rst_n         = rst[i];
      @(negedge clk);
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++;
        $display("FAIL halt_reset_cycle%0d: got %b exp %b", i, outs(), exp[i]);
      end
      tick();
    end
    rst_n = 1'b1;
    bus.irq_mask_i = 4'h0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_irq_priority();
    test_branch();
    test_wfi();
    test_halt_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
